// File: rtl/spram_access_arbiter.sv
// spram_access_arbiter: round-robin arbiter serializing write and read requests onto a single-port RAM with a 4-entry read response FIFO
module spram_access_arbiter #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int MASK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_wr_valid,
    output logic                  s_wr_ready,
    input  logic [ADDR_WIDTH-1:0] s_wr_addr,
    input  logic [DATA_WIDTH-1:0] s_wr_data,
    input  logic [MASK_WIDTH-1:0] s_wr_mask,
    input  logic                  s_rd_valid,
    output logic                  s_rd_ready,
    input  logic [ADDR_WIDTH-1:0] s_rd_addr,
    output logic                  m_rd_valid,
    input  logic                  m_rd_ready,
    output logic [DATA_WIDTH-1:0] m_rd_data,
    output logic [DATA_WIDTH-1:0] ram_writeData,
    output logic                  ram_writeCs,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_writeAddr,
    output logic [MASK_WIDTH-1:0] ram_writeMask,
    output logic                  ram_readCs,
    output logic [ADDR_WIDTH-1:0] ram_readAddr,
    input  logic [DATA_WIDTH-1:0] ram_readData
);
    typedef enum logic {WR, RD} grant_t;
    grant_t last_grant, last_nxt;
    logic inflight;
    logic [DATA_WIDTH-1:0] fifo [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic rd_allowed, wr_ok, rd_ok, grant_wr, grant_rd, pop;
    // Read admission counts the read already on the RAM port so a full FIFO can never be overrun
    always_comb begin
        rd_allowed = ({1'b0, count} + {3'b000, inflight}) < 4'd4;
        wr_ok      = s_wr_valid & ~reset;
        rd_ok      = s_rd_valid & rd_allowed & ~reset;
        grant_wr   = wr_ok & (~rd_ok | (last_grant == RD));
        grant_rd   = rd_ok & (~wr_ok | (last_grant == WR));
        last_nxt   = grant_wr ? WR : grant_rd ? RD : last_grant;
    end
    assign s_wr_ready    = grant_wr;
    assign s_rd_ready    = grant_rd;
    assign ram_write     = grant_wr;
    assign ram_writeCs   = grant_wr;
    assign ram_readCs    = grant_rd;
    assign ram_writeAddr = s_wr_addr;
    assign ram_writeData = s_wr_data;
    assign ram_writeMask = s_wr_mask;
    assign ram_readAddr  = s_rd_addr;
    assign m_rd_valid    = (count != 3'd0) & ~reset;
    assign m_rd_data     = fifo[rd_ptr];
    assign pop           = m_rd_valid & m_rd_ready;
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= RD;
            inflight   <= 1'b0;
            count      <= 3'd0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
        end else begin
            last_grant <= last_nxt;
            inflight   <= grant_rd;
            if (inflight) begin
                fifo[wr_ptr] <= ram_readData;
                wr_ptr       <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b00, inflight} - {2'b00, pop};
        end
    end
endmodule

// File: tb/tb_spram_access_arbiter.sv
// tb_spram_access_arbiter: directed test of the arbiter against a masked RAM model with a queue scoreboard on read responses
module tb_spram_access_arbiter;
    localparam int AW = 14, DW = 16, MW = 4, LW = DW / MW;
    logic clk = 0, reset;
    logic s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready, m_rd_valid, m_rd_ready;
    logic [AW-1:0] s_wr_addr, s_rd_addr, ram_writeAddr, ram_readAddr;
    logic [DW-1:0] s_wr_data, m_rd_data, ram_writeData, ram_readData;
    logic [MW-1:0] s_wr_mask, ram_writeMask;
    logic ram_writeCs, ram_write, ram_readCs;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] rd_exp;
    int total = 0, bad = 0, resp_cnt = 0;

    always #5 clk = ~clk;

    spram_access_arbiter dut (
        .clk(clk), .reset(reset),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_addr(s_wr_addr),
        .s_wr_data(s_wr_data), .s_wr_mask(s_wr_mask),
        .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_addr(s_rd_addr),
        .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_data(m_rd_data),
        .ram_writeData(ram_writeData), .ram_writeCs(ram_writeCs), .ram_write(ram_write),
        .ram_writeAddr(ram_writeAddr), .ram_writeMask(ram_writeMask),
        .ram_readCs(ram_readCs), .ram_readAddr(ram_readAddr), .ram_readData(ram_readData)
    );

    // Single-port RAM model: masked lane writes, read data one cycle after readCs
    always @(posedge clk) begin
        if (ram_writeCs && ram_write)
            for (int l = 0; l < MW; l++)
                if (ram_writeMask[l]) mem[ram_writeAddr][l*LW +: LW] <= ram_writeData[l*LW +: LW];
        if (ram_readCs) ram_readData <= mem[ram_readAddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (reset) exp_q.delete();
        else begin
            if (m_rd_valid && m_rd_ready) begin
                resp_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_resp: got %0h expected none at %0t", m_rd_data, $time);
                end else chk("rd_data", 32'(m_rd_data), 32'(exp_q.pop_front()));
            end
            if (s_rd_valid && s_rd_ready) exp_q.push_back(rd_exp);
            if (dut.count > 3'd4) begin
                bad++;
                $display("FAIL count_overflow: got %0d expected <=4 at %0t", dut.count, $time);
            end
            if (ram_readCs && ram_writeCs) begin
                bad++;
                $display("FAIL strobe_excl: got both expected one at %0t", $time);
            end
        end
    end

    task automatic wr_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m, input logic [DW-1:0] e);
        s_wr_valid = 1; s_wr_addr = a; s_wr_data = d; s_wr_mask = m;
        @(negedge clk);
        chk("wr_ready", 32'(s_wr_ready), 1);
        chk("wr_strobe", 32'(ram_writeCs & ram_write & ~ram_readCs), 1);
        step;
        s_wr_valid = 0; s_rd_valid = 1; s_rd_addr = a; rd_exp = e;
        @(negedge clk);
        chk("rd_ready", 32'(s_rd_ready), 1);
        chk("rd_strobe", 32'(ram_readCs & ~ram_writeCs), 1);
        step;
        s_rd_valid = 0;
        @(negedge clk);
        chk("rd_lat_n1", 32'(m_rd_valid), 0);
        step;
        @(negedge clk);
        chk("rd_lat_n2", 32'(m_rd_valid), 1);
        step;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wn, rn, rd_idx;
        reset = 1; s_wr_valid = 1; s_rd_valid = 1; m_rd_ready = 1;
        s_wr_addr = 0; s_wr_data = 0; s_wr_mask = 0; s_rd_addr = 0; rd_exp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wr_ready", 32'(s_wr_ready), 0);
            chk("rst_rd_ready", 32'(s_rd_ready), 0);
            chk("rst_m_valid", 32'(m_rd_valid), 0);
            chk("rst_strobes", 32'(ram_writeCs | ram_write | ram_readCs), 0);
        end
        step;
        reset = 0; s_wr_valid = 0; s_rd_valid = 0;
        wr_rd(14'h0010, 16'hBEEF, 4'b1111, 16'hBEEF);
        wr_rd(14'h0010, 16'h1234, 4'b0011, 16'hBE34);
        // Last grant was a read, so contention must open with a write
        s_wr_valid = 1; s_wr_addr = 14'h0030; s_wr_data = 16'hA5A5; s_wr_mask = 4'hF;
        s_rd_valid = 1; s_rd_addr = 14'h0010; rd_exp = 16'hBE34;
        wn = 0; rn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("cont_wr", 32'(s_wr_ready), 32'(i % 2 == 0));
            chk("cont_rd", 32'(s_rd_ready), 32'(i % 2 == 1));
            wn += int'(s_wr_ready); rn += int'(s_rd_ready);
            step;
        end
        s_wr_valid = 0; s_rd_valid = 0;
        chk("cont_writes", 32'(wn), 4);
        chk("cont_reads", 32'(rn), 4);
        repeat (3) step;
        for (int i = 0; i < 16; i++) begin
            s_wr_valid = 1; s_wr_addr = AW'(i); s_wr_data = DW'(i); s_wr_mask = 4'hF;
            @(negedge clk);
            chk("preload_wr", 32'(s_wr_ready), 1);
            step;
        end
        s_wr_valid = 0;
        rd_idx = 0;
        for (int c = 0; c < 15; c++) begin
            s_rd_valid = rd_idx < 6; s_rd_addr = AW'(rd_idx); rd_exp = DW'(rd_idx);
            s_wr_valid = (c == 6); s_wr_addr = 14'h0050; s_wr_data = 16'h5555; s_wr_mask = 4'hF;
            m_rd_ready = (c >= 7);
            @(negedge clk);
            if (c <= 8) chk("bp_rd_ready", 32'(s_rd_ready), 32'(c < 4 || c == 8));
            if (c == 6) chk("bp_wr_ready", 32'(s_wr_ready), 1);
            if (c == 7) chk("bp_head_valid", 32'(m_rd_valid), 1);
            if (s_rd_valid && s_rd_ready) rd_idx++;
            step;
        end
        s_rd_valid = 0; s_wr_valid = 0;
        chk("bp_reads", 32'(rd_idx), 6);
        for (int c = 0; c < 19; c++) begin
            s_rd_valid = c < 16; s_rd_addr = AW'(c); rd_exp = DW'(c);
            @(negedge clk);
            if (c < 16) chk("stream_rd_ready", 32'(s_rd_ready), 1);
            chk("stream_valid", 32'(m_rd_valid), 32'(c >= 2 && c < 18));
            step;
        end
        m_rd_ready = 0;
        for (int c = 0; c < 3; c++) begin
            s_rd_valid = 1; s_rd_addr = AW'(c); rd_exp = DW'(c);
            @(negedge clk);
            chk("mf_rd_ready", 32'(s_rd_ready), 1);
            step;
        end
        s_rd_valid = 0; reset = 1;
        @(negedge clk);
        chk("mf_valid_in_reset", 32'(m_rd_valid), 0);
        step;
        reset = 0;
        @(negedge clk);
        chk("mf_count", 32'(dut.count), 0);
        m_rd_ready = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mf_no_stale", 32'(m_rd_valid), 0);
            step;
        end
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("resp_total", 32'(resp_cnt), 28);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
